// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions used by the substitution encoder and the polar stage.
package hdb3_pkg;

  // Symbol alphabet carried between the substitution encoder and the polar stage.
  typedef enum logic [1:0] {
    SYM_0 = 2'b00,
    SYM_1 = 2'b01,
    SYM_B = 2'b10,
    SYM_V = 2'b11
  } sym_t;

  // Line states produced by the polar stage.
  typedef enum logic [1:0] {
    POL_Z = 2'b00,
    POL_P = 2'b01,
    POL_N = 2'b10
  } pol_t;

  // Symbol pipeline depth: B must reach back to the first zero of a four-zero run.
  localparam int unsigned PIPE_DEPTH = 4;

  // Length of a zero run that triggers substitution.
  localparam int unsigned ZRUN_LEN   = 4;

  // True for symbols that put a pulse on the line (1, B and V).
  function automatic logic sym_is_pulse(input sym_t s);
    return (s != SYM_0);
  endfunction

endpackage

// File: rtl/hdb3_sub_enc_if.sv
// Bit-in / symbol-out bus of the HDB3 substitution encoder.
interface hdb3_sub_enc_if;
  logic       bit_en;
  logic       data_in;
  logic [1:0] code_out;
  logic       code_valid;
  logic       v_strobe;

  // Source of NRZ bits, sink of HDB3 symbols.
  modport master (
    output bit_en,
    output data_in,
    input  code_out,
    input  code_valid,
    input  v_strobe
  );

  // The encoder itself.
  modport slave (
    input  bit_en,
    input  data_in,
    output code_out,
    output code_valid,
    output v_strobe
  );
endinterface

// File: rtl/hdb3_sub_enc.sv
// HDB3 zero-substitution encoder: NRZ bits in, 0/1/B/V symbols out through a
// four-deep symbol pipeline so that B can replace the first zero of a run.
module hdb3_sub_enc
  import hdb3_pkg::*;
#(
  parameter logic INIT_PARITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  hdb3_sub_enc_if.slave bus
);

  sym_t       r_sr [PIPE_DEPTH];
  logic [1:0] r_zcnt;
  logic       r_parity;
  logic [2:0] r_fill;
  logic       r_v_strobe;

  logic       w_fourth_zero;
  sym_t       w_new_sym;
  sym_t       w_head_sym;

  // Classify the incoming bit and pick the symbols entering sr[0] and sr[3].
  always_comb begin
    w_fourth_zero = !bus.data_in && (r_zcnt == 2'(ZRUN_LEN - 1));
    w_new_sym     = SYM_0;
    w_head_sym    = r_sr[2];
    if (bus.data_in) begin
      w_new_sym = SYM_1;
    end else if (w_fourth_zero) begin
      w_new_sym = SYM_V;
      // The first zero of the run is moving into sr[3] on this same edge;
      // even parity turns it into B, odd parity leaves it a plain zero.
      w_head_sym = r_parity ? SYM_0 : SYM_B;
    end
  end

  // Symbol shift register, newest in sr[0], oldest (output) in sr[3].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        r_sr[i] <= SYM_0;
      end
    end else if (bus.bit_en) begin
      r_sr[3] <= w_head_sym;
      r_sr[2] <= r_sr[1];
      r_sr[1] <= r_sr[0];
      r_sr[0] <= w_new_sym;
    end
  end

  // Zero-run counter and pulse parity since the last V.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zcnt   <= '0;
      r_parity <= INIT_PARITY;
    end else if (bus.bit_en) begin
      if (bus.data_in) begin
        r_zcnt   <= '0;
        r_parity <= ~r_parity;
      end else if (w_fourth_zero) begin
        r_zcnt   <= '0;
        r_parity <= 1'b0;
      end else begin
        r_zcnt   <= r_zcnt + 2'd1;
      end
    end
  end

  // Saturating count of real bits in the pipeline since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (bus.bit_en && (r_fill != 3'(PIPE_DEPTH))) begin
      r_fill <= r_fill + 3'd1;
    end
  end

  // One-clock marker for each V inserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_strobe <= 1'b0;
    end else begin
      r_v_strobe <= bus.bit_en && w_fourth_zero;
    end
  end

  assign bus.code_out   = r_sr[3];
  assign bus.code_valid = (r_fill == 3'(PIPE_DEPTH));
  assign bus.v_strobe   = r_v_strobe;

endmodule

// File: tb/tb_hdb3_sub_enc.sv
// Self-checking bench for hdb3_sub_enc against a stream-level HDB3 model.
module tb_hdb3_sub_enc;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hdb3_sub_enc_if bus();

  hdb3_sub_enc #(.INIT_PARITY(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: full symbol history since reset, substitution applied in place.
  logic [1:0] m_sym[$];
  logic       m_par;
  int         m_z;
  logic       m_v;
  logic       chk_on = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_sym.delete();
    m_par = 1'b0;
    m_z   = 0;
    m_v   = 1'b0;
  endfunction

  function automatic void model_step(input logic en, input logic d);
    if (!en) begin
      m_v = 1'b0;
    end else if (d) begin
      m_sym.push_back(2'b01);
      m_par = ~m_par;
      m_z   = 0;
      m_v   = 1'b0;
    end else if (m_z == 3) begin
      m_sym.push_back(2'b11);
      if (!m_par) m_sym[m_sym.size() - 4] = 2'b10;
      m_par = 1'b0;
      m_z   = 0;
      m_v   = 1'b1;
    end else begin
      m_sym.push_back(2'b00);
      m_z++;
      m_v = 1'b0;
    end
  endfunction

  function automatic logic [1:0] exp_code();
    int n = m_sym.size();
    return (n >= 4) ? m_sym[n - 4] : 2'b00;
  endfunction

  function automatic logic exp_valid();
    return (m_sym.size() >= 4);
  endfunction

  // Check the first n model symbols against a hand-written packed literal.
  task automatic pin(input string name, input int n, input logic [31:0] lit);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      v = (v << 2) | ((i < m_sym.size()) ? 32'(m_sym[i]) : 32'hF);
    end
    check(name, v, lit);
  endtask

  task automatic cycle(input logic en, input logic d);
    bus.bit_en  = en;
    bus.data_in = d;
    @(posedge clk);
    model_step(en, d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_code_out", 32'(bus.code_out), 32'd0);
    check("rst_code_valid", 32'(bus.code_valid), 32'd0);
    check("rst_v_strobe", 32'(bus.v_strobe), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Feed n bits MSB-first, optionally idling between bits, then flush with ones.
  task automatic feed(input logic [31:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b1, bits[i]);
      if (gap) cycle(1'b0, 1'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("code_out", 32'(bus.code_out), 32'(exp_code()));
      check("code_valid", 32'(bus.code_valid), 32'(exp_valid()));
      check("v_strobe", 32'(bus.v_strobe), 32'(m_v));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.bit_en  = 1'b0;
    bus.data_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    do_reset();
    feed(32'b1111, 4, 1'b0);
    pin("A_ones", 4, 32'b01_01_01_01);

    do_reset();
    feed(32'b0000, 4, 1'b0);
    pin("B_b00v", 4, 32'b10_00_00_11);

    do_reset();
    feed(32'b10000, 5, 1'b0);
    pin("C_000v", 5, 32'b01_00_00_00_11);

    do_reset();
    feed(32'b1100000000, 10, 1'b0);
    pin("D_b00v_b00v", 10, 32'b01_01_10_00_00_11_10_00_00_11);

    do_reset();
    feed(32'b100000000, 9, 1'b0);
    pin("G_000v_b00v", 9, 32'b01_00_00_00_11_10_00_00_11);

    do_reset();
    feed(32'b10000, 5, 1'b1);
    pin("E_gapped", 5, 32'b01_00_00_00_11);

    do_reset();
    feed(32'b1000000, 7, 1'b0);
    pin("H_run7", 7, 32'b01_00_00_00_11_00_00);

    // Reset with three zeros pending: the next zero must be a plain zero.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0);
    pin("F_post_rst_zero", 1, 32'b00);
    feed(32'b000, 3, 1'b0);
    pin("F_post_rst_run", 4, 32'b10_00_00_11);

    // Randomized stream with zero-heavy data, idle cycles and sporadic resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
